decoder_hold: RTL and testbench

Registered 3-to-8 decoder with a valid/ready input handshake and a timed one-hot output pulse. It accepts a 3-bit code `D` and drives the matching bit of `I` high for exactly `HOLD_CYCLES` clocks. It then idles for `GAP_CYCLES` clocks before it accepts the next code. It is the receiving end of the 8-to-3 encoder path and turns encoded selects back into one-hot line strobes.

---
 rtl/decoder_hold.sv | 126 ++++++++++++
 tb/tb_decoder_hold.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_hold.sv
// decoder_hold: registered 3-to-8 decoder with a valid/ready input handshake.
// An accepted code drives one bit of I for HOLD_CYCLES clocks. The block then
// stays dead for GAP_CYCLES clocks before it accepts the next code.
// Optional feature macro: DECODER_HOLD_PARITY_EN. When it is defined, P is
// checked against the XOR of D. A code with bad parity is consumed without
// producing a pulse and raises a one-cycle err.
module decoder_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] D,
    input  logic       P,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] I,
    output logic       out_valid,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [7:0] i_nx;
    logic       out_valid_nx;
    logic       err_nx;
    logic       accept;
    logic       parity_ok;

`ifdef DECODER_HOLD_PARITY_EN
    assign parity_ok = (P == (D[2] ^ D[1] ^ D[0]));
`else
    logic unused_p;
    assign unused_p  = P;
    assign parity_ok = 1'b1;
`endif

    // in_ready depends only on state and rst; reset masks it straight away.
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // Next-state logic. The counter is loaded at the start of each phase and stops at zero.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        i_nx         = I;
        out_valid_nx = out_valid;
        err_nx       = 1'b0;
        case (state)
            IDLE: begin
                i_nx         = 8'h00;
                out_valid_nx = 1'b0;
                if (accept) begin
                    if (parity_ok) begin
                        i_nx         = 8'b1 << D;
                        out_valid_nx = 1'b1;
                        cnt_nx       = HOLD_LOAD;
                        state_nx     = HOLD;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else begin
                    i_nx         = 8'h00;
                    out_valid_nx = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx   = GAP_LOAD;
                        state_nx = GAP;
                    end
                end
            end
            GAP: begin
                i_nx         = 8'h00;
                out_valid_nx = 1'b0;
                if (cnt == 8'd0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx     = IDLE;
                cnt_nx       = 8'd0;
                i_nx         = 8'h00;
                out_valid_nx = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset takes priority and cuts any pulse short.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            I         <= 8'h00;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            I         <= i_nx;
            out_valid <= out_valid_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_decoder_hold.sv
// tb_decoder_hold: testbench for decoder_hold.
// Instance a uses the defaults (hold 4, gap 1). Instance b uses hold 1, gap 0.
// Both instances are compared every cycle against a timeline model. The bench
// also runs a table of hand-computed vectors and a few directed sequences.
module tb_decoder_hold;

    localparam int H_A = 4;
    localparam int G_A = 1;
    localparam int H_B = 1;
    localparam int G_B = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] d_a, d_b;
    logic       p_a, p_b, v_a, v_b;
    logic       rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b, err_a, err_b;
    logic [7:0] i_a, i_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int acc_edge[2];
    int code[2];
    int err_edge[2];
    int hold_len[2];
    int gap_len[2];

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] d;
        logic       p;
        logic [7:0] i;
        logic       ov;
        logic       rdy;
        logic       busy;
    } vec_t;

    vec_t tbl[18];

    always #5 clk = ~clk;

    decoder_hold #(.HOLD_CYCLES(H_A), .GAP_CYCLES(G_A)) dut_a (
        .clk(clk), .rst(rst), .D(d_a), .P(p_a), .in_valid(v_a),
        .in_ready(rdy_a), .I(i_a), .out_valid(ov_a), .busy(busy_a), .err(err_a)
    );

    decoder_hold #(.HOLD_CYCLES(H_B), .GAP_CYCLES(G_B)) dut_b (
        .clk(clk), .rst(rst), .D(d_b), .P(p_b), .in_valid(v_b),
        .in_ready(rdy_b), .I(i_b), .out_valid(ov_b), .busy(busy_b), .err(err_b)
    );

    // Model: the block is idle after edge t once the last accepted code's hold and gap have elapsed.
    function automatic bit idle_after(int k, int t);
        return t >= acc_edge[k] + hold_len[k] + gap_len[k];
    endfunction

    function automatic logic [7:0] exp_i(int k, int t);
        logic [7:0] one;
        one = 8'h01;
        if (t >= acc_edge[k] && t <= acc_edge[k] + hold_len[k] - 1)
            return one << code[k];
        return 8'h00;
    endfunction

    // Updates the model at edge t, using the inputs the DUT samples at that edge.
    task automatic model_edge(int t);
        logic       v, p;
        logic [2:0] d;
        for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? v_a : v_b;
            d = (k == 0) ? d_a : d_b;
            p = (k == 0) ? p_a : p_b;
            if (rst) begin
                acc_edge[k] = -1000;
                err_edge[k] = -1000;
            end else if (v && idle_after(k, t - 1)) begin
`ifdef DECODER_HOLD_PARITY_EN
                if (p != (d[2] ^ d[1] ^ d[0])) begin
                    err_edge[k] = t;
                end else begin
                    acc_edge[k] = t;
                    code[k]     = int'(d);
                end
`else
                acc_edge[k] = t;
                code[k]     = int'(d);
`endif
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic checkDut(int k);
        logic [7:0] ai;
        logic       aov, ardy, abusy, aerr;
        logic [7:0] ei;
        ai    = (k == 0) ? i_a : i_b;
        aov   = (k == 0) ? ov_a : ov_b;
        ardy  = (k == 0) ? rdy_a : rdy_b;
        abusy = (k == 0) ? busy_a : busy_b;
        aerr  = (k == 0) ? err_a : err_b;
        ei    = exp_i(k, cyc);
        checkOutput((k == 0) ? "a_I" : "b_I", 32'(ai), 32'(ei));
        checkOutput((k == 0) ? "a_out_valid" : "b_out_valid", 32'(aov), 32'(ei != 8'h00));
        checkOutput((k == 0) ? "a_in_ready" : "b_in_ready", 32'(ardy), 32'(!rst && idle_after(k, cyc)));
        checkOutput((k == 0) ? "a_busy" : "b_busy", 32'(abusy), 32'(!idle_after(k, cyc)));
        checkOutput((k == 0) ? "a_err" : "b_err", 32'(aerr), 32'(cyc == err_edge[k]));
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check 1 time unit later.
    task automatic applyStimulus(input logic r, input logic va, input logic [2:0] da, input logic pa,
                                 input logic vb, input logic [2:0] db, input logic pb);
        @(negedge clk);
        rst = r;
        v_a = va; d_a = da; p_a = pa;
        v_b = vb; d_b = db; p_b = pb;
        @(posedge clk);
        cyc++;
        model_edge(cyc);
        #1;
        checkDut(0);
        checkDut(1);
    endtask

    // Time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int prev_acc;
        int n;
        logic [2:0] rd;

        hold_len[0] = H_A; gap_len[0] = G_A;
        hold_len[1] = H_B; gap_len[1] = G_B;
        for (int k = 0; k < 2; k++) begin
            acc_edge[k] = -1000;
            err_edge[k] = -1000;
            code[k]     = 0;
        end
        rst = 1'b1;
        v_a = 1'b0; d_a = 3'd0; p_a = 1'b0;
        v_b = 1'b0; d_b = 3'd0; p_b = 1'b0;

        // Hand-computed vectors for instance a: {rst, valid, D, P, I, out_valid, in_ready, busy}.
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd5, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'h20, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 3'd1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 3'd1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 3'd1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 3'd1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 3'd7, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 3'd7, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 3'd7, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};

        $display("[TB] table vectors");
        for (int r = 0; r < 18; r++) begin
            applyStimulus(tbl[r].rst, tbl[r].v, tbl[r].d, tbl[r].p, 1'b0, 3'd0, 1'b0);
            checkOutput("tbl_I", 32'(i_a), 32'(tbl[r].i));
            checkOutput("tbl_out_valid", 32'(ov_a), 32'(tbl[r].ov));
            checkOutput("tbl_in_ready", 32'(rdy_a), 32'(tbl[r].rdy));
            checkOutput("tbl_busy", 32'(busy_a), 32'(tbl[r].busy));
        end

        $display("[TB] hold 1 gap 0 with valid held high");
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1);
            checkOutput("b_alternate", 32'(i_b), (j % 2 == 0) ? 32'h04 : 32'h00);
        end

`ifdef DECODER_HOLD_PARITY_EN
        $display("[TB] parity error and recovery");
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("par_err_pulse", 32'(err_a), 32'd1);
        checkOutput("par_err_I", 32'(i_a), 32'h00);
        checkOutput("par_err_ready", 32'(rdy_a), 32'd1);
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("par_ok_err", 32'(err_a), 32'd0);
        checkOutput("par_ok_I", 32'(i_a), 32'h08);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0);
            checkOutput("par_hold_I", 32'(i_a), 32'h08);
        end
`endif

        $display("[TB] sweep of all codes with valid held high");
        prev_acc = 0;
        for (int c = 0; c < 8; c++) begin
            rd = 3'(c);
            n  = 0;
            do begin
                applyStimulus(1'b0, 1'b1, rd, rd[2] ^ rd[1] ^ rd[0], 1'b0, 3'd0, 1'b0);
                n++;
            end while (acc_edge[0] != cyc && n < 20);
            if (acc_edge[0] != cyc) begin
                checks++;
                failures++;
                $display("[TB] FAIL sweep_accept code=%0d no acceptance within 20 cycles", c);
            end
            checkOutput("sweep_code", 32'(i_a), 32'(8'h01 << c));
            if (c > 0)
                checkOutput("sweep_period", 32'(cyc - prev_acc), 32'(H_A + G_A + 1));
            prev_acc = cyc;
        end

        $display("[TB] randomized traffic");
        for (int j = 0; j < 2000; j++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
